lfsr_16_checker: RTL and testbench

Receive-side companion to the 16-bit LFSR generator. It samples the generator's 16-bit output word whenever `enable` is high, self-synchronises to the sequence, and declares lock. Once locked, it flags and counts every word that deviates from the predicted next value. It sits at the far end of a link or datapath under test and provides a pass/fail signal and an error tally for bench and on-chip BIST use.

---
 rtl/lfsr_16_checker.sv | 113 +++++++++++
 tb/tb_lfsr_16_checker.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_16_checker.sv
// Receive-side checker for the x^16+x^14+x^13+x^11+1 LFSR stream: self-synchronises,
// declares lock, then flags and counts every word that deviates from the prediction.
//
// state  | meaning
// SEARCH | acquiring: counting consecutive correct transitions toward lock
// LOCKED | synchronised: mismatches pulse error, are counted, and the flywheel keeps predicting
`timescale 1ns/1ps
module lfsr_16_checker #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [15:0]      lfsr,
    input  logic             clear_err,
    output logic             locked,
    output logic             error,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic {SEARCH, LOCKED} state_t;

    localparam logic [3:0]       LOCK_C  = 4'(LOCK_CNT);
    localparam logic [3:0]       LOSS_C  = 4'(LOSS_CNT);
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    state_t           state_q, state_d;
    logic [15:0]      ref_q, ref_d;
    logic             have_ref_q, have_ref_d;
    logic [3:0]       match_cnt_q, match_cnt_d;
    logic [3:0]       miss_cnt_q, miss_cnt_d;
    logic             error_q, error_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [15:0]      pred;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= SEARCH;
            ref_q       <= '0;
            have_ref_q  <= 1'b0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            error_q     <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            ref_q       <= ref_d;
            have_ref_q  <= have_ref_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            error_q     <= error_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ref_d       = ref_q;
        have_ref_d  = have_ref_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        error_d     = 1'b0;
        err_cnt_d   = err_cnt_q;
        pred        = lfsr_next(ref_q);

        if (enable) begin
            if (state_q == SEARCH) begin
                // zero is the lock-up state, so it can never advance acquisition
                if (have_ref_q && (lfsr == pred) && (lfsr != 16'h0000)) begin
                    match_cnt_d = match_cnt_q + 4'd1;
                    if (match_cnt_d == LOCK_C) begin
                        state_d    = LOCKED;
                        miss_cnt_d = '0;
                    end
                end else begin
                    match_cnt_d = '0;
                end
                ref_d      = lfsr;
                have_ref_d = 1'b1;
            end else begin
                if (lfsr == pred) begin
                    ref_d      = lfsr;
                    miss_cnt_d = '0;
                end else begin
                    error_d    = 1'b1;
                    if (err_cnt_q != ERR_MAX)
                        err_cnt_d = err_cnt_q + 1'b1;
                    ref_d      = pred;
                    miss_cnt_d = miss_cnt_q + 4'd1;
                    if (miss_cnt_d == LOSS_C) begin
                        state_d     = SEARCH;
                        match_cnt_d = '0;
                        ref_d       = lfsr;
                    end
                end
            end
        end

        if (clear_err)
            err_cnt_d = '0;
    end

    assign locked    = (state_q == LOCKED);
    assign error     = error_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_lfsr_16_checker.sv
// Bench for lfsr_16_checker: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a behavioural model.
`timescale 1ns/1ps
module tb_lfsr_16_checker;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        clear_err = 1'b0;
    logic [15:0] lfsr = 16'h0000;
    logic        locked, error, locked4, error4;
    logic [15:0] err_count;
    logic [3:0]  err_count4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lfsr_16_checker dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .lfsr(lfsr), .clear_err(clear_err),
        .locked(locked), .error(error), .err_count(err_count)
    );

    lfsr_16_checker #(.ERR_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .lfsr(lfsr), .clear_err(clear_err),
        .locked(locked4), .error(error4), .err_count(err_count4)
    );

    // Successor via tap mask 0xB400 (bits 15,13,12,10) and parity.
    function automatic logic [15:0] nx(input logic [15:0] v);
        logic [15:0] s;
        s = v << 1;
        s[0] = ^(v & 16'hB400);
        return s;
    endfunction

    // Predecessor: inverse of nx.
    function automatic logic [15:0] prv(input logic [15:0] n);
        logic [15:0] v;
        v = {1'b0, n[15:1]};
        v[15] = n[0] ^ n[14] ^ n[13] ^ n[11];
        return v;
    endfunction

    // Behavioural reference model
    bit          m_locked, m_have, m_error;
    logic [15:0] m_ref;
    int          m_match, m_miss, m_err16, m_err4;

    task automatic model_edge();
        if (!reset_n) begin
            m_locked = 0; m_have = 0; m_error = 0; m_ref = 16'h0;
            m_match = 0; m_miss = 0; m_err16 = 0; m_err4 = 0;
            return;
        end
        m_error = 0;
        if (enable) begin
            if (!m_locked) begin
                if (m_have && lfsr == nx(m_ref) && lfsr != 16'h0) begin
                    m_match++;
                    if (m_match == 4) begin m_locked = 1; m_miss = 0; end
                end else m_match = 0;
                m_ref = lfsr; m_have = 1;
            end else if (lfsr == nx(m_ref)) begin
                m_ref = lfsr; m_miss = 0;
            end else begin
                m_error = 1;
                if (m_err16 < 65535) m_err16++;
                if (m_err4 < 15) m_err4++;
                m_ref = nx(m_ref);
                m_miss++;
                if (m_miss == 3) begin m_locked = 0; m_match = 0; m_ref = lfsr; end
            end
        end
        if (clear_err) begin m_err16 = 0; m_err4 = 0; end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic en, input logic [15:0] w, input logic clr);
        enable = en; lfsr = w; clear_err = clr;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step(1'b0, 16'h0, 1'b0);
        reset_n = 1'b1;
    endtask

    task automatic lock_on(input logic [15:0] target);
        logic [15:0] w [5];
        w[4] = target;
        for (int i = 3; i >= 0; i--) w[i] = prv(w[i+1]);
        for (int i = 0; i < 5; i++) step(1'b1, w[i], 1'b0);
    endtask

    task automatic check_model();
        chk("rand_locked", {31'b0, locked}, {31'b0, m_locked});
        chk("rand_error", {31'b0, error}, {31'b0, m_error});
        chk("rand_err16", {16'b0, err_count}, m_err16);
        chk("rand_err4", {28'b0, err_count4}, m_err4);
        chk("rand_locked4", {31'b0, locked4}, {31'b0, m_locked});
    endtask

    typedef struct {
        logic        en;
        logic [15:0] w;
        logic        clr;
        logic        lk;
        logic        er;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl [10];

    initial begin
        logic [15:0] g;
        int burst;
        bit bad;

        tbl[0] = '{1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[1] = '{1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[2] = '{1'b1, 16'h0004, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[3] = '{1'b1, 16'h0008, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[4] = '{1'b1, 16'h0010, 1'b0, 1'b1, 1'b0, 16'd0};
        tbl[5] = '{1'b1, 16'h0020, 1'b0, 1'b1, 1'b0, 16'd0};
        tbl[6] = '{1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1, 16'd1};
        tbl[7] = '{1'b1, 16'h0080, 1'b0, 1'b1, 1'b0, 16'd1};
        tbl[8] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'd1};
        tbl[9] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'd0};

        // Reset values
        do_reset();
        chk("rst_locked", {31'b0, locked}, 0);
        chk("rst_error", {31'b0, error}, 0);
        chk("rst_err", {16'b0, err_count}, 0);
        chk("rst_err4", {28'b0, err_count4}, 0);

        // Acquire, flywheel over one bad word, gap, clear
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].en, tbl[i].w, tbl[i].clr);
            chk($sformatf("tbl%0d_locked", i), {31'b0, locked}, {31'b0, tbl[i].lk});
            chk($sformatf("tbl%0d_error", i), {31'b0, error}, {31'b0, tbl[i].er});
            chk($sformatf("tbl%0d_err", i), {16'b0, err_count}, {16'b0, tbl[i].cnt});
        end

        // Single corruption around 0xACE1
        do_reset();
        lock_on(prv(16'hACE1));
        chk("corr_prelock", {31'b0, locked}, 1);
        step(1'b1, 16'hACE1, 1'b0);
        chk("corr_ace1_error", {31'b0, error}, 0);
        step(1'b1, 16'h1234, 1'b0);
        chk("corr_bad_error", {31'b0, error}, 1);
        chk("corr_bad_err", {16'b0, err_count}, 1);
        chk("corr_bad_locked", {31'b0, locked}, 1);
        step(1'b1, nx(16'h59C3), 1'b0);
        chk("corr_after_error", {31'b0, error}, 0);
        chk("corr_after_locked", {31'b0, locked}, 1);
        chk("corr_after_err", {16'b0, err_count}, 1);

        // Loss of lock and re-acquisition
        do_reset();
        lock_on(16'h1D2C);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'h0000, 1'b0);
            chk($sformatf("loss%0d_error", i), {31'b0, error}, 1);
            chk($sformatf("loss%0d_err", i), {16'b0, err_count}, i + 1);
            chk($sformatf("loss%0d_locked", i), {31'b0, locked}, (i < 2) ? 1 : 0);
        end
        g = 16'h7777;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, g, 1'b0);
            g = nx(g);
            chk($sformatf("relock%0d_locked", i), {31'b0, locked}, (i == 4) ? 1 : 0);
            chk($sformatf("relock%0d_error", i), {31'b0, error}, 0);
        end

        // Zero lock-up
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 16'h0000, 1'b0);
            chk($sformatf("zero%0d_locked", i), {31'b0, locked}, 0);
        end
        chk("zero_err", {16'b0, err_count}, 0);

        // Enable gaps, then clear coinciding with a mismatch
        do_reset();
        lock_on(16'h0001);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'hDEAD, 1'b0);
            chk($sformatf("gap%0d_error", i), {31'b0, error}, 0);
            chk($sformatf("gap%0d_locked", i), {31'b0, locked}, 1);
        end
        step(1'b1, 16'h0002, 1'b0);
        chk("gap_resume_error", {31'b0, error}, 0);
        chk("gap_resume_locked", {31'b0, locked}, 1);
        g = 16'h0002;
        for (int k = 0; k < 5; k++) begin
            g = nx(g); step(1'b1, ~g, 1'b0);
            g = nx(g); step(1'b1, g, 1'b0);
        end
        chk("clr_pre_err", {16'b0, err_count}, 5);
        g = nx(g);
        step(1'b1, ~g, 1'b1);
        chk("clr_error", {31'b0, error}, 1);
        chk("clr_err", {16'b0, err_count}, 0);
        chk("clr_locked", {31'b0, locked}, 1);

        // Saturation on the 4-bit counter, then reset while locked
        do_reset();
        lock_on(16'hBEEF);
        g = 16'hBEEF;
        for (int k = 0; k < 20; k++) begin
            g = nx(g); step(1'b1, 16'h0000, 1'b0);
            g = nx(g); step(1'b1, g, 1'b0);
        end
        chk("sat_err4", {28'b0, err_count4}, 15);
        chk("sat_err16", {16'b0, err_count}, 20);
        chk("sat_locked4", {31'b0, locked4}, 1);
        reset_n = 1'b0;
        step(1'b1, nx(g), 1'b0);
        reset_n = 1'b1;
        chk("mid_rst_locked", {31'b0, locked}, 0);
        chk("mid_rst_locked4", {31'b0, locked4}, 0);
        chk("mid_rst_error", {31'b0, error}, 0);
        chk("mid_rst_err", {16'b0, err_count}, 0);
        chk("mid_rst_err4", {28'b0, err_count4}, 0);

        // Randomized traffic against the model
        do_reset();
        g = 16'h5A5A;
        burst = 0;
        for (int c = 0; c < 4000; c++) begin
            reset_n = ($urandom_range(0, 399) != 0);
            bad = 0;
            if (burst > 0) begin
                bad = 1; burst--;
            end else if ($urandom_range(0, 99) < 3) begin
                bad = 1;
            end else if ($urandom_range(0, 199) == 0) begin
                burst = $urandom_range(2, 5);
            end
            if ($urandom_range(0, 299) == 0) begin
                g = 16'($urandom);
                if (g == 16'h0) g = 16'h0001;
            end
            if ($urandom_range(0, 9) < 8) begin
                g = nx(g);
                step(1'b1, bad ? (($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom)) : g,
                     ($urandom_range(0, 49) == 0));
            end else begin
                step(1'b0, 16'($urandom), ($urandom_range(0, 49) == 0));
            end
            check_model();
        end
        reset_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
